// File: rtl/fb_bram_arbiter_pkg.sv
// Shared constants and types for the frame-buffer BRAM arbiter.
package fb_bram_arbiter_pkg;

  localparam int FB_ADDR_W = 19;
  localparam int FB_DATA_W = 12;
  localparam int FB_RD_LAT = 1;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  // The page select sits directly above the pixel address on the BRAM port.
  localparam int PAGE_BIT = FB_ADDR_W;

  typedef enum logic {
    REQ_NOTE = 1'b0,
    REQ_BG   = 1'b1
  } req_id_e;

  function automatic req_id_e other_req(input req_id_e id);
    return (id == REQ_NOTE) ? REQ_BG : REQ_NOTE;
  endfunction

endpackage

// File: rtl/fb_bram_arbiter_rr_arb2.sv
// Two-input round-robin arbiter; a requester granted in the current cycle is masked
// because its request line still shows the transaction being committed.
module rr_arb2
  import fb_bram_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  input  logic [1:0] stale,
  output logic [1:0] gnt
);

  req_id_e    ptr;
  logic [1:0] elig;

  always_comb begin
    elig = req & ~stale;
    gnt  = 2'b00;
    if (en) begin
      if (&elig) begin
        gnt = (ptr == REQ_NOTE) ? 2'b01 : 2'b10;
      end else begin
        gnt = elig;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= REQ_NOTE;
    end else if (|gnt) begin
      ptr <= other_req(gnt[REQ_BG] ? REQ_BG : REQ_NOTE);
    end
  end

endmodule

// File: rtl/fb_bram_arbiter.sv
// Frame-buffer BRAM port owner: display reads have absolute priority, two writers share
// the remaining cycles round-robin, and front/back pages swap only at frame start.
module fb_bram_arbiter
  import fb_bram_arbiter_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DATA_W = FB_DATA_W,
  parameter int RD_LAT = FB_RD_LAT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                disp_req,
  input  logic [ADDR_W-1:0]   disp_addr,
  input  logic                frame_start,
  input  logic [1:0]          wr_req,
  input  logic [2*ADDR_W-1:0] wr_addr,
  input  logic [2*DATA_W-1:0] wr_data,
  output logic [1:0]          wr_gnt,
  input  logic                swap_req,
  output logic                swap_pend,
  output logic                page,
  output logic                bram_en,
  output logic                bram_we,
  output logic [ADDR_W:0]     bram_addr,
  output logic [DATA_W-1:0]   bram_din,
  input  logic [DATA_W-1:0]   bram_dout,
  output logic [DATA_W-1:0]   pix_data,
  output logic                pix_valid
);

  logic [1:0]        arb_gnt;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [RD_LAT:0]   rd_pipe;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (!disp_req),
    .req   (wr_req),
    .stale (wr_gnt),
    .gnt   (arb_gnt)
  );

  always_comb begin
    sel_addr = wr_addr[ADDR_W-1:0];
    sel_data = wr_data[DATA_W-1:0];
    if (arb_gnt[REQ_BG]) begin
      sel_addr = wr_addr[2*ADDR_W-1:ADDR_W];
      sel_data = wr_data[2*DATA_W-1:DATA_W];
    end
  end

  // Address and data hold their last value on idle cycles to avoid needless toggling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bram_en   <= 1'b0;
      bram_we   <= 1'b0;
      bram_addr <= '0;
      bram_din  <= '0;
      wr_gnt    <= 2'b00;
    end else begin
      bram_en <= disp_req | (|arb_gnt);
      bram_we <= |arb_gnt;
      wr_gnt  <= arb_gnt;
      if (disp_req) begin
        bram_addr <= {page, disp_addr};
      end else if (|arb_gnt) begin
        bram_addr <= {~page, sel_addr};
        bram_din  <= sel_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pipe   <= '0;
      pix_valid <= 1'b0;
      pix_data  <= '0;
    end else begin
      rd_pipe   <= {rd_pipe[RD_LAT-1:0], disp_req};
      pix_valid <= rd_pipe[RD_LAT];
      pix_data  <= rd_pipe[RD_LAT] ? bram_dout : '0;
    end
  end

  // A swap request arriving with frame_start is honoured at that same frame_start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      page      <= 1'b0;
      swap_pend <= 1'b0;
    end else if (frame_start && (swap_pend || swap_req)) begin
      page      <= ~page;
      swap_pend <= 1'b0;
    end else if (swap_req) begin
      swap_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fb_bram_arbiter.sv
// Directed bench for fb_bram_arbiter with a per-cycle behavioural model and BRAM stand-in.
module tb_fb_bram_arbiter;

  localparam int AW = 19;
  localparam int DW = 12;
  localparam int RL = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          disp_req = 1'b0;
  logic [AW-1:0] disp_addr = '0;
  logic          frame_start = 1'b0;
  logic [1:0]    wr_req = 2'b00;
  logic [2*AW-1:0] wr_addr = '0;
  logic [2*DW-1:0] wr_data = '0;
  logic [1:0]    wr_gnt;
  logic          swap_req = 1'b0;
  logic          swap_pend;
  logic          page;
  logic          bram_en;
  logic          bram_we;
  logic [AW:0]   bram_addr;
  logic [DW-1:0] bram_din;
  logic [DW-1:0] bram_dout;
  logic [DW-1:0] pix_data;
  logic          pix_valid;

  always #5 clk = ~clk;

  fb_bram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL)) dut (
    .clk(clk), .rst_n(rst_n), .disp_req(disp_req), .disp_addr(disp_addr),
    .frame_start(frame_start), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_gnt(wr_gnt), .swap_req(swap_req), .swap_pend(swap_pend), .page(page),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
    .bram_dout(bram_dout), .pix_data(pix_data), .pix_valid(pix_valid)
  );

  // Unwritten BRAM locations read back as a fixed function of their address.
  function automatic logic [DW-1:0] init_pix(input logic [AW:0] a);
    return a[DW-1:0] ^ 12'hA5C;
  endfunction

  // BRAM stand-in
  logic [DW-1:0] bmem [int];
  logic [DW-1:0] rd_q1 = '0;
  logic [DW-1:0] rd_q2 = '0;

  function automatic logic [DW-1:0] bram_rd(input logic [AW:0] a);
    return bmem.exists(int'(a)) ? bmem[int'(a)] : init_pix(a);
  endfunction

  always @(posedge clk) begin
    if (bram_en && bram_we) bmem[int'(bram_addr)] = bram_din;
    if (bram_en && !bram_we) rd_q1 <= bram_rd(bram_addr);
    rd_q2 <= rd_q1;
  end
  assign bram_dout = (RL == 1) ? rd_q1 : rd_q2;

  // Behavioural model: expected outputs for the cycle following each edge.
  logic          e_en = 1'b0, e_we = 1'b0, e_pv = 1'b0, e_page = 1'b0, e_pend = 1'b0;
  logic [AW:0]   e_addr = '0;
  logic [DW-1:0] e_din = '0, e_pd = '0;
  logic [1:0]    e_gnt = 2'b00;
  logic          m_last = 1'b1;
  int            mcyc = 0;
  logic [DW-1:0] exp_pix [int];
  logic [DW-1:0] mmem [int];

  function automatic logic [DW-1:0] mm_rd(input logic [AW:0] a);
    return mmem.exists(int'(a)) ? mmem[int'(a)] : init_pix(a);
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    logic          n_en, n_we;
    logic [AW:0]   n_addr;
    logic [DW-1:0] n_din;
    logic [1:0]    n_gnt, elig;
    int            w;
    if (!rst_n) begin
      e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_din = '0; e_gnt = 2'b00;
      e_pv = 1'b0; e_pd = '0; e_page = 1'b0; e_pend = 1'b0; m_last = 1'b1;
      exp_pix.delete();
    end else begin
      if (e_en && e_we) mmem[int'(e_addr)] = e_din;
      mcyc++;
      n_en = 1'b0; n_we = 1'b0; n_addr = e_addr; n_din = e_din; n_gnt = 2'b00;
      if (disp_req) begin
        n_en = 1'b1;
        n_addr = {e_page, disp_addr};
        exp_pix[mcyc + 1 + RL] = mm_rd(n_addr);
      end else begin
        elig = wr_req & ~e_gnt;
        w = -1;
        if (elig == 2'b11) w = (m_last == 1'b1) ? 0 : 1;
        else if (elig[0]) w = 0;
        else if (elig[1]) w = 1;
        if (w >= 0) begin
          n_en = 1'b1; n_we = 1'b1; n_gnt[w] = 1'b1; m_last = w[0];
          n_addr = {~e_page, wr_addr[w*AW +: AW]};
          n_din = wr_data[w*DW +: DW];
        end
      end
      if (frame_start && (e_pend || swap_req)) begin
        e_page = ~e_page;
        e_pend = 1'b0;
      end else if (swap_req) begin
        e_pend = 1'b1;
      end
      e_en = n_en; e_we = n_we; e_addr = n_addr; e_din = n_din; e_gnt = n_gnt;
      e_pv = exp_pix.exists(mcyc);
      e_pd = e_pv ? exp_pix[mcyc] : '0;
      if (e_pv) exp_pix.delete(mcyc);
    end
  end

  int checks = 0, errors = 0;
  int n_gnt = 0, n_rd = 0, n_consec = 0;
  logic [1:0] prev_gnt = 2'b00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_cycle();
    check("bram_en", 32'(bram_en), 32'(e_en));
    check("bram_we", 32'(bram_we), 32'(e_we));
    check("wr_gnt", 32'(wr_gnt), 32'(e_gnt));
    check("pix_valid", 32'(pix_valid), 32'(e_pv));
    check("pix_data", 32'(pix_data), 32'(e_pd));
    check("page", 32'(page), 32'(e_page));
    check("swap_pend", 32'(swap_pend), 32'(e_pend));
    if (e_en) check("bram_addr", 32'(bram_addr), 32'(e_addr));
    if (e_we) check("bram_din", 32'(bram_din), 32'(e_din));
    if (wr_gnt != 2'b00) n_gnt++;
    if (bram_en && !bram_we) n_rd++;
    if ((wr_gnt & prev_gnt) != 2'b00) n_consec++;
    prev_gnt = wr_gnt;
  endtask

  // Write requesters: hold a request until granted, then advance address and data.
  int            rq_left [2] = '{0, 0};
  logic [AW-1:0] rq_addr [2] = '{19'h00100, 19'h00200};
  logic [DW-1:0] rq_dat  [2] = '{12'h100, 12'h800};

  task automatic drive_rq();
    for (int i = 0; i < 2; i++) begin
      wr_req[i] = (rq_left[i] > 0);
      wr_addr[i*AW +: AW] = rq_addr[i];
      wr_data[i*DW +: DW] = rq_dat[i];
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare_cycle();
    for (int i = 0; i < 2; i++) begin
      if (wr_gnt[i] && rq_left[i] > 0) begin
        rq_left[i]--;
        rq_addr[i]++;
        rq_dat[i] += 12'h111;
      end
    end
    drive_rq();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, r;
    // Reset held with inputs toggling
    rq_left[0] = 3; rq_left[1] = 3;
    drive_rq();
    for (int i = 0; i < 4; i++) begin
      disp_req = (i % 2 == 1);
      frame_start = (i >= 2);
      swap_req = (i % 2 == 0);
      disp_addr = 19'(i + 1);
      tick();
    end
    check("rst_ctl", 32'({bram_en, bram_we, wr_gnt, pix_valid, page, swap_pend}), 32'd0);
    check("rst_addr", 32'(bram_addr), 32'd0);
    check("rst_din", 32'(bram_din), 32'd0);
    check("rst_pix", 32'(pix_data), 32'd0);
    rq_left[0] = 0; rq_left[1] = 0;
    disp_req = 1'b0; frame_start = 1'b0; swap_req = 1'b0;
    drive_rq();
    tick();
    rst_n = 1'b1;

    // First read after release
    disp_req = 1'b1; disp_addr = 19'd5;
    tick();
    check("rd_en", 32'(bram_en), 32'd1);
    check("rd_we", 32'(bram_we), 32'd0);
    check("rd_addr", 32'(bram_addr), 32'h00005);
    disp_req = 1'b0;
    tick();
    check("pv_t2", 32'(pix_valid), 32'd0);
    tick();
    check("pv_t3", 32'(pix_valid), 32'd1);
    check("pd_t3", 32'(pix_data), 32'hA59);
    tick();
    check("pv_t4", 32'(pix_valid), 32'd0);

    // Display priority over both writers
    g = n_gnt; r = n_rd;
    rq_left[0] = 40; rq_left[1] = 40;
    drive_rq();
    for (int i = 0; i < 10; i++) begin
      disp_req = 1'b1;
      disp_addr = 19'(100 + i);
      tick();
    end
    check("prio_gnts", 32'(n_gnt - g), 32'd0);
    check("prio_reads", 32'(n_rd - r), 32'd10);
    disp_req = 1'b0;
    tick();
    check("prio_release_gnt", 32'(wr_gnt), 32'b01);
    check("prio_release_addr", 32'(bram_addr), 32'h80100);
    check("prio_release_din", 32'(bram_din), 32'h100);

    // Round-robin with both held
    g = n_gnt;
    for (int i = 0; i < 8; i++) tick();
    check("rr_gnts", 32'(n_gnt - g), 32'd8);
    check("rr_last_gnt", 32'(wr_gnt), 32'b01);
    check("rr_consec", 32'(n_consec), 32'd0);
    rq_left[0] = 0; rq_left[1] = 0;
    rq_left[1] = 4;
    drive_rq();

    // Single requester: one grant per two cycles
    g = n_gnt;
    for (int i = 0; i < 8; i++) tick();
    check("single_gnts", 32'(n_gnt - g), 32'd4);
    check("single_consec", 32'(n_consec), 32'd0);

    // Swap request, repeated request, then frame start
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    check("swap_pend1", 32'({page, swap_pend}), 32'b01);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    check("swap_pend2", 32'({page, swap_pend}), 32'b01);
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("swap_done", 32'({page, swap_pend}), 32'b10);

    // Writes now target page 0, reads page 1
    rq_left[0] = 1; rq_addr[0] = 19'h00050; rq_dat[0] = 12'h5A5;
    drive_rq();
    tick();
    check("swapped_wr_gnt", 32'(wr_gnt), 32'b01);
    check("swapped_wr_addr", 32'(bram_addr), 32'h00050);
    check("swapped_wr_din", 32'(bram_din), 32'h5A5);
    disp_req = 1'b1; disp_addr = 19'h00101;
    tick();
    check("swapped_rd_addr", 32'(bram_addr), 32'h80101);
    disp_req = 1'b0;
    tick();
    tick();
    check("readback_valid", 32'(pix_valid), 32'd1);
    check("readback_data", 32'(pix_data), 32'h211);

    // swap_req coincident with frame_start
    swap_req = 1'b1; frame_start = 1'b1;
    tick();
    swap_req = 1'b0; frame_start = 1'b0;
    check("coincident_swap", 32'({page, swap_pend}), 32'b00);

    // Async reset in the middle of a grant with a swap pending
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    check("pre_rst_pend", 32'(swap_pend), 32'd1);
    rq_left[0] = 6; rq_left[1] = 6;
    drive_rq();
    tick();
    @(posedge clk);
    #2;
    check("mid_gnt_active", 32'(wr_gnt != 2'b00), 32'd1);
    check("mid_pend_active", 32'(swap_pend), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_ctl", 32'({bram_en, bram_we, wr_gnt, pix_valid, page, swap_pend}), 32'd0);
    check("async_addr", 32'(bram_addr), 32'd0);
    check("async_din", 32'(bram_din), 32'd0);
    disp_req = 1'b1; frame_start = 1'b1; swap_req = 1'b1;
    tick();
    disp_req = 1'b0; frame_start = 1'b0; swap_req = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    check("post_rst_page", 32'(page), 32'd0);
    check("post_rst_drained", 32'(rq_left[0] + rq_left[1]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
